// File: rtl/macbank_pkg.sv
// Shared constants and types for the MAC bank readout path: bank geometry,
// readout controller states and the streamed output word.
package macbank_pkg;

  localparam int N_LANES    = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } out_word_t;

endpackage

// File: rtl/mac_rd_fifo.sv
// Synchronous skid FIFO for readout words; the head is presented directly and
// the occupancy count feeds the issue-credit check in the controller.
module mac_rd_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && (count != CNT_W'(DEPTH));
  assign do_rd   = rd_en && (count != CNT_W'(0));
  assign rd_data = mem[rd_ptr];
  assign valid   = (count != CNT_W'(0));

  // Storage, pointers and occupancy; storage is zeroed on reset so the head reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_bank_reader.sv
// Readout controller for the RAM-based MAC bank: sweeps lanes 0..N_LANES-1 over
// the bank read port, streams tagged words over valid/ready, optionally clears.
module mac_bank_reader #(
  parameter int N_LANES    = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr_en,
  output logic              busy,
  output logic              read,
  output logic [ADDR_W-1:0] rAddr,
  output logic              clr,
  input  logic [DATA_W-1:0] rData,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              dout_valid,
  input  logic              dout_ready
);

  import macbank_pkg::state_t;
  import macbank_pkg::ST_IDLE;
  import macbank_pkg::ST_ARM;
  import macbank_pkg::ST_ISSUE;
  import macbank_pkg::ST_DRAIN;
  import macbank_pkg::ST_CLEAR;

  localparam int WORD_W = DATA_W + ADDR_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W   = $clog2(RD_LAT + 1);
  localparam int CR_W   = FCNT_W + IF_W;
  localparam int CLR_W  = $clog2(N_LANES + 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_LANES - 1);
  localparam logic [CLR_W-1:0]  CLR_END  = CLR_W'(N_LANES + 1);

  state_t              state;
  state_t              next_state;
  logic                issue;
  logic                accept;
  logic                has_credit;
  logic                pending;
  logic [IF_W-1:0]     inflight;
  logic                clr_latch;
  logic [CLR_W-1:0]    clr_cnt;
  logic [RD_LAT-1:0]   tag_valid;
  logic [ADDR_W-1:0]   tag_idx [RD_LAT];
  logic [FCNT_W-1:0]   fifo_count;
  logic [WORD_W-1:0]   fifo_wdata;
  logic [WORD_W-1:0]   fifo_rdata;
  logic                fifo_pop;

  assign accept     = (state == ST_IDLE) && start && (fifo_count == FCNT_W'(0));
  assign has_credit = (CR_W'(fifo_count) + CR_W'(inflight)) < CR_W'(FIFO_DEPTH);
  assign fifo_wdata = {rData, tag_idx[RD_LAT-1], (tag_idx[RD_LAT-1] == LAST_IDX)};
  assign {dout, dout_idx, dout_last} = fifo_rdata;
  assign fifo_pop   = dout_valid && dout_ready;

  // Tags in flight, and whether any will still be in flight after this edge
  always_comb begin
    inflight = '0;
    pending  = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IF_W'(tag_valid[i]);
      pending  = pending | (tag_valid[i] & (i < RD_LAT - 1));
    end
  end

  // Next-state and issue decision
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_ARM;
        else        next_state = ST_IDLE;
      end
      ST_ARM: begin
        issue      = 1'b1;
        next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue = has_credit;
        if (has_credit && (rAddr == LAST_IDX)) next_state = ST_DRAIN;
        else                                   next_state = ST_ISSUE;
      end
      ST_DRAIN: begin
        // leave as the final tag exits, so read drops with the last capture
        if (!pending) next_state = clr_latch ? ST_CLEAR : ST_IDLE;
        else          next_state = ST_DRAIN;
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_END) next_state = ST_IDLE;
        else                    next_state = ST_CLEAR;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register, read address and registered bank-side control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rAddr     <= '0;
      read      <= 1'b0;
      busy      <= 1'b0;
      clr       <= 1'b0;
      clr_latch <= 1'b0;
      clr_cnt   <= '0;
    end else begin
      state   <= next_state;
      read    <= (next_state == ST_ARM) || (next_state == ST_ISSUE) || (next_state == ST_DRAIN);
      busy    <= (next_state != ST_IDLE);
      clr     <= (next_state == ST_CLEAR) && (state != ST_CLEAR);
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      if (accept) clr_latch <= clr_en;
      case (state)
        ST_ARM:   rAddr <= ADDR_W'(1);
        ST_ISSUE: begin
          if (issue && (rAddr != LAST_IDX)) rAddr <= rAddr + ADDR_W'(1);
        end
        ST_DRAIN: rAddr <= rAddr;
        default:  rAddr <= '0;
      endcase
    end
  end

  // Read-latency tag pipeline matching each issued index to its returning data
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      tag_valid[0] <= issue;
      tag_idx[0]   <= rAddr;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
    end
  end

  mac_rd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tag_valid[RD_LAT-1]),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .valid   (dout_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mac_bank_reader.sv
// Bench for mac_bank_reader: behavioural bank (RD_LAT=2 read, 32-cycle clear)
// and expectations taken from the readout timing rules.
module tb_mac_bank_reader;
  import macbank_pkg::*;

  localparam int NL = 32;

  logic        clk = 1'b0;
  logic        rst, start, clr_en, dout_ready;
  logic        busy, read, clr, dout_valid, dout_last;
  logic [4:0]  rAddr, dout_idx;
  logic [31:0] rData, dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram     [NL];
  logic [31:0] ref_ram [NL];
  logic [31:0] pipe1;
  logic        load;
  int          clr_left;

  always #5 clk = ~clk;

  mac_bank_reader dut (
    .clk(clk), .rst(rst), .start(start), .clr_en(clr_en), .busy(busy),
    .read(read), .rAddr(rAddr), .clr(clr), .rData(rData), .dout(dout),
    .dout_idx(dout_idx), .dout_last(dout_last), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  // Bank model: two-cycle registered read, clear sweeps one lane per cycle
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NL; i++) ram[i] <= ref_ram[i];
    end else if (clr_left > 0) begin
      ram[NL - clr_left] <= 32'd0;
      clr_left <= clr_left - 1;
    end
    if (clr) clr_left <= NL;
    if (read) pipe1 <= ram[rAddr];
    rData <= pipe1;
  end

  task automatic load_bank(input bit rnd);
    for (int i = 0; i < NL; i++) ref_ram[i] = rnd ? $urandom : (i * 32'h01010101);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, read, clr, dout_valid, dout_last} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=00000", {busy, read, clr, dout_valid, dout_last});
    end
    n_tests++;
    if ({rAddr, dout_idx, dout} !== 42'd0) begin
      n_fail++; $display("FAIL reset_data got=%h/%h/%h exp=0", rAddr, dout_idx, dout);
    end
    rst = 1'b0;
  endtask

  // Full sweep with ready held high; every cycle checked against the timing table
  task automatic test_readout(input bit use_clr, input string name);
    logic [2:0] exp_ctl;
    int k;
    @(negedge clk); start = 1'b1; clr_en = use_clr; dout_ready = 1'b1;
    for (int t = 1; t <= 75; t++) begin
      @(negedge clk); start = 1'b0; clr_en = 1'b0;
      exp_ctl = {(use_clr ? (t <= 68) : (t <= 34)), (t <= 34), (use_clr && t == 35)};
      n_tests++;
      if ({busy, read, clr} !== exp_ctl) begin
        n_fail++; $display("FAIL %s ctl t=%0d got=%b exp=%b", name, t, {busy, read, clr}, exp_ctl);
      end
      n_tests++;
      if (dout_valid !== (t >= 4 && t <= 35)) begin
        n_fail++; $display("FAIL %s valid t=%0d got=%b exp=%b", name, t, dout_valid, (t >= 4 && t <= 35));
      end
      if (t >= 4 && t <= 35) begin
        k = t - 4;
        n_tests++;
        if ({dout, dout_idx, dout_last} !== {ref_ram[k], 5'(k), (k == NL - 1)}) begin
          n_fail++; $display("FAIL %s word t=%0d got=%h/%0d/%b exp=%h/%0d/%b", name, t,
                             dout, dout_idx, dout_last, ref_ram[k], k, (k == NL - 1));
        end
      end
    end
  endtask

  // Consumer ready one cycle in three: order, completeness, FIFO bound, read continuity
  task automatic test_stall();
    int got = 0;
    bit saw_read = 0, read_fell = 0;
    int t = 0;
    out_word_t exp_w;
    @(negedge clk); start = 1'b1; clr_en = 1'b0; dout_ready = 1'b0;
    while (!(got == NL && !busy) && t < 400) begin
      @(negedge clk); start = 1'b0; t++;
      dout_ready = (t % 3 == 0);
      if (read && read_fell) begin
        n_tests++; n_fail++; $display("FAIL stall_read_gap t=%0d got=1 exp=0", t);
      end
      if (read) saw_read = 1;
      if (!read && saw_read) read_fell = 1;
      n_tests++;
      if (dut.u_fifo.count > 3'd4 || clr !== 1'b0) begin
        n_fail++; $display("FAIL stall_bound t=%0d count=%0d clr=%b exp<=4/0", t, dut.u_fifo.count, clr);
      end
      if (dout_valid && dout_ready) begin
        exp_w = '{data: ref_ram[got], idx: 5'(got), last: (got == NL - 1)};
        n_tests++;
        if ({dout, dout_idx, dout_last} !== exp_w) begin
          n_fail++; $display("FAIL stall_word n=%0d got=%h/%0d/%b exp=%h/%0d/%b", got,
                             dout, dout_idx, dout_last, exp_w.data, exp_w.idx, exp_w.last);
        end
        got++;
      end
    end
    n_tests++;
    if (got !== NL || busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_done got=%0d busy=%b exp=%0d/0", got, busy, NL);
    end
    dout_ready = 1'b1;
    @(negedge clk);
  endtask

  // start during readout, and again in IDLE with words still queued: both ignored
  task automatic test_start_ignored();
    int exp_idx;
    bit exp_v;
    @(negedge clk); start = 1'b1; clr_en = 1'b0; dout_ready = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      @(negedge clk);
      start      = (t == 10 || t == 36);
      dout_ready = (t <= 33 || t >= 41);
      exp_v   = (t >= 4 && t <= 42);
      exp_idx = (t <= 33) ? t - 4 : ((t <= 41) ? 30 : 31);
      n_tests++;
      if ({busy, read, clr, dout_valid} !== {(t <= 34), (t <= 34), 1'b0, exp_v}) begin
        n_fail++; $display("FAIL ignore_ctl t=%0d got=%b exp=%b", t, {busy, read, clr, dout_valid},
                           {(t <= 34), (t <= 34), 1'b0, exp_v});
      end
      if (exp_v) begin
        n_tests++;
        if ({dout, dout_idx, dout_last} !== {ref_ram[exp_idx], 5'(exp_idx), (exp_idx == NL - 1)}) begin
          n_fail++; $display("FAIL ignore_word t=%0d got=%h/%0d exp=%h/%0d", t, dout, dout_idx,
                             ref_ram[exp_idx], exp_idx);
        end
      end
    end
    start = 1'b0; dout_ready = 1'b1;
  endtask

  // Reset while issuing index 10, then a fresh readout from index 0
  task automatic test_reset_mid();
    int t = 0;
    @(negedge clk); start = 1'b1; clr_en = 1'b1; dout_ready = 1'b1;
    @(negedge clk); start = 1'b0; clr_en = 1'b0;
    while (!(read && busy && rAddr == 5'd10) && t < 60) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (t >= 60) begin
      n_fail++; $display("FAIL rstmid_reach got=timeout exp=rAddr10");
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_tests++;
    if ({busy, read, clr, dout_valid, dout_last, rAddr} !== 10'd0 || dout !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_outs got=%b/%h exp=0", {busy, read, clr, dout_valid, dout_last, rAddr}, dout);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, clr} !== 2'b00) begin
        n_fail++; $display("FAIL rstmid_idle i=%0d got=%b exp=00", i, {busy, clr});
      end
    end
    test_readout(1'b0, "after_rst");
  endtask

  task automatic test_start_rst();
    @(negedge clk); rst = 1'b1; start = 1'b1; clr_en = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0; clr_en = 1'b0;
    n_tests++;
    if ({busy, read} !== 2'b00) begin
      n_fail++; $display("FAIL start_rst_a got=%b exp=00", {busy, read});
    end
    @(negedge clk);
    n_tests++;
    if ({busy, read, clr} !== 3'b000) begin
      n_fail++; $display("FAIL start_rst_b got=%b exp=000", {busy, read, clr});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr_en = 1'b0; dout_ready = 1'b0;
    load = 1'b0; clr_left = 0; pipe1 = 32'd0;
    test_reset();
    load_bank(1'b0);
    test_readout(1'b0, "nominal");
    test_readout(1'b1, "clear");
    for (int i = 0; i < NL; i++) ref_ram[i] = 32'd0;
    test_readout(1'b0, "after_clear");
    load_bank(1'b1);
    test_stall();
    load_bank(1'b1);
    test_start_ignored();
    load_bank(1'b1);
    test_reset_mid();
    test_start_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
